// File: rtl/scan_pkg.sv
// Shared definitions for the address scan controller.
// Holds the controller state encoding and the slot/address geometry
// used by addr_scan_ctrl and next_slot_find.
package scan_pkg;

  // Number of decoder outputs being scanned and the address width feeding them.
  localparam int NUM_SLOTS = 8;
  localparam int ADDR_W    = 3;

  // IDLE: waiting for start; SCAN: driving the decoder; DONE: one-cycle wrap-up.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/next_slot_find.sv
// Combinational search for the next enabled slot in an 8-bit slot mask.
// Ports: mask_i (slot enables), cur_i (current slot), first_i (search from
//   below slot 0), next_o (lowest qualifying slot), found_o (a slot qualified).
module next_slot_find
  import scan_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] mask_i,
  input  logic [ADDR_W-1:0]    cur_i,
  input  logic                 first_i,
  output logic [ADDR_W-1:0]    next_o,
  output logic                 found_o
);

  // Walk from the top slot down so the last qualifying hit, i.e. the lowest
  // index, is the one that sticks. With first_i set, cur_i is treated as
  // lying below slot 0 so every set bit qualifies.
  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (mask_i[i] && (first_i || (i > int'(cur_i)))) begin
        next_o  = ADDR_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/addr_scan_ctrl.sv
// Address scan controller: steps a 3-to-8 decoder through the enabled slots
// of a latched mask, holding each slot for dwell+1 cycles, then pulses done.
// Ports: clk, rst (sync, active-high), start, abort, mask, dwell in;
//   A (decoder address), E (decoder enable), busy, done out; all registered.
// Build option: define SCAN_WRAP_EN to loop over the mask continuously
//   instead of finishing after the highest enabled slot.
module addr_scan_ctrl
  import scan_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_SLOTS-1:0] mask,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [ADDR_W-1:0]    A,
  output logic                 E,
  output logic                 busy,
  output logic                 done
);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    a_q, a_d;
  logic                 e_q, e_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [NUM_SLOTS-1:0] mask_q, mask_d;

  // First-slot search: in IDLE the live mask is searched so the first slot
  // can be loaded in the same cycle the mask is latched; otherwise the
  // latched copy is searched (used when wrapping back to the lowest slot).
  logic [NUM_SLOTS-1:0] first_mask;
  logic [ADDR_W-1:0]    first_slot;
  logic                 first_found;
  logic [ADDR_W-1:0]    next_slot;
  logic                 next_found;

  assign first_mask = (state_q == IDLE) ? mask : mask_q;

  next_slot_find u_first (
    .mask_i  (first_mask),
    .cur_i   (a_q),
    .first_i (1'b1),
    .next_o  (first_slot),
    .found_o (first_found)
  );

  next_slot_find u_next (
    .mask_i  (mask_q),
    .cur_i   (a_q),
    .first_i (1'b0),
    .next_o  (next_slot),
    .found_o (next_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      dwell_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    e_d     = e_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    mask_d  = mask_q;

    unique case (state_q)
      IDLE: begin
        e_d    = 1'b0;
        busy_d = 1'b0;
        // abort outranks start even here: the request is simply dropped.
        if (start && !abort) begin
          mask_d  = mask;
          dwell_d = dwell;
          busy_d  = 1'b1;
          if (first_found) begin
            state_d = SCAN;
            a_d     = first_slot;
            e_d     = 1'b1;
            cnt_d   = dwell;
          end else begin
            // Empty mask: nothing to drive, report completion straight away.
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      SCAN: begin
        if (abort) begin
          state_d = IDLE;
          e_d     = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (next_found) begin
          // Slot expired: move straight to the next slot with E kept high.
          a_d   = next_slot;
          cnt_d = dwell_q;
        end else begin
`ifdef SCAN_WRAP_EN
          // Past the highest slot: restart at the lowest one, E kept high.
          a_d   = first_slot;
          cnt_d = dwell_q;
`else
          // Past the highest slot: A keeps its last value through DONE.
          state_d = DONE;
          e_d     = 1'b0;
          done_d  = 1'b1;
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
        e_d     = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        e_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign A    = a_q;
  assign E    = e_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_addr_scan_ctrl.sv
// Self-checking bench for addr_scan_ctrl: table of scan vectors with a
// per-cycle scoreboard, plus abort / reset / wrap corner sequences.
module tb_addr_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] mask;
  logic [3:0] dwell;
  logic [2:0] A;
  logic       E;
  logic       busy;
  logic       done;

  addr_scan_ctrl #(.DWELL_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .mask  (mask),
    .dwell (dwell),
    .A     (A),
    .E     (E),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] a;
    logic       e;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    logic [7:0] mask;
    logic [3:0] dwell;
    int         exp_e;
    logic [2:0] exp_last;
  } vec_t;

  obs_t       exp_q[$];
  logic [2:0] model_a;
  int         checks;
  int         errors;

  function automatic obs_t sample();
    return obs_t'({A, E, busy, done});
  endfunction

  function automatic obs_t mk(input logic [2:0] a, input logic e,
                              input logic b, input logic d);
    return obs_t'({a, e, b, d});
  endfunction

  task automatic check_obs(input string nm, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got A=%0d E=%0b busy=%0b done=%0b, expected A=%0d E=%0b busy=%0b done=%0b",
               nm, got.a, got.e, got.busy, got.done, exp.a, exp.e, exp.busy, exp.done);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where outputs are sampled
  // and new inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle outputs for one single-pass scan, derived from the
  // behaviour: each set bit ascending held dwell+1 cycles with E=1, then one
  // DONE cycle (E=0, busy=1, done=1, A held), then idle.
  task automatic push_scan(input logic [7:0] m, input logic [3:0] d);
    for (int n = 0; n < 8; n++) begin
      if (m[n]) begin
        for (int k = 0; k <= int'(d); k++) exp_q.push_back(mk(3'(n), 1'b1, 1'b1, 1'b0));
        model_a = 3'(n);
      end
    end
    exp_q.push_back(mk(model_a, 1'b0, 1'b1, 1'b1));
    exp_q.push_back(mk(model_a, 1'b0, 1'b0, 1'b0));
  endtask

  // Pop and compare one expectation per cycle; mask/dwell are scrambled
  // after the start edge since the scan must ignore them.
  task automatic drain(input string nm, output int ecount);
    obs_t exp;
    ecount = 0;
    while (exp_q.size() > 0) begin
      step();
      start = 1'b0;
      mask  = 8'($urandom);
      dwell = 4'($urandom);
      exp   = exp_q.pop_front();
      check_obs(nm, sample(), exp);
      if (E) ecount++;
    end
  endtask

  initial begin
    vec_t tbl[6];
    int   ecount;
    tbl[0] = '{8'hFF,        4'd0,  8,  3'd7};
    tbl[1] = '{8'b1010_0100, 4'd2,  9,  3'd7};
    tbl[2] = '{8'h00,        4'd3,  0,  3'd7};
    tbl[3] = '{8'h11,        4'd1,  4,  3'd4};
    tbl[4] = '{8'h80,        4'd0,  1,  3'd7};
    tbl[5] = '{8'h01,        4'd15, 16, 3'd0};

    checks  = 0;
    errors  = 0;
    model_a = 3'd0;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    mask  = 8'h00;
    dwell = 4'd0;
    step();
    step();
    check_obs("reset", sample(), mk(3'd0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    step();
    check_obs("idle_after_reset", sample(), mk(3'd0, 1'b0, 1'b0, 1'b0));

`ifdef SCAN_WRAP_EN
    // Two-slot mask wraps 0,7,0,7... with E continuously high, never done.
    mask  = 8'b1000_0001;
    dwell = 4'd0;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      start = 1'b0;
      check_obs("wrap_seq", sample(), mk((i % 2 == 0) ? 3'd0 : 3'd7, 1'b1, 1'b1, 1'b0));
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_obs("wrap_abort", sample(), mk(3'd7, 1'b0, 1'b0, 1'b0));
    step();
    check_obs("wrap_idle", sample(), mk(3'd7, 1'b0, 1'b0, 1'b0));
    // Empty mask still reports completion in wrap mode.
    mask  = 8'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    check_obs("wrap_zero_done", sample(), mk(3'd7, 1'b0, 1'b1, 1'b1));
    step();
    check_obs("wrap_zero_idle", sample(), mk(3'd7, 1'b0, 1'b0, 1'b0));
`else
    // Table of complete single-pass scans.
    for (int i = 0; i < 6; i++) begin
      mask  = tbl[i].mask;
      dwell = tbl[i].dwell;
      start = 1'b1;
      push_scan(tbl[i].mask, tbl[i].dwell);
      drain($sformatf("scan%0d", i), ecount);
      check_int($sformatf("scan%0d_e_cycles", i), ecount, tbl[i].exp_e);
      check_int($sformatf("scan%0d_last_a", i), int'(A), int'(tbl[i].exp_last));
    end

    // abort in IDLE, alone and together with start, changes nothing.
    abort = 1'b1;
    step();
    check_obs("abort_idle", sample(), mk(model_a, 1'b0, 1'b0, 1'b0));
    start = 1'b1;
    mask  = 8'hFF;
    step();
    check_obs("start_abort_idle", sample(), mk(model_a, 1'b0, 1'b0, 1'b0));
    start = 1'b0;
    abort = 1'b0;
    step();
    check_obs("still_idle", sample(), mk(model_a, 1'b0, 1'b0, 1'b0));

    // abort on the 6th SCAN cycle of mask=FF, dwell=3.
    mask  = 8'hFF;
    dwell = 4'd3;
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      start = 1'b0;
      check_obs("abort_pre", sample(), mk((i < 4) ? 3'd0 : 3'd1, 1'b1, 1'b1, 1'b0));
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_obs("abort_scan", sample(), mk(3'd1, 1'b0, 1'b0, 1'b0));
    step();
    check_obs("abort_no_done", sample(), mk(3'd1, 1'b0, 1'b0, 1'b0));
    model_a = 3'd1;
    mask  = 8'h02;
    dwell = 4'd0;
    start = 1'b1;
    push_scan(8'h02, 4'd0);
    drain("restart", ecount);
    check_int("restart_e_cycles", ecount, 1);

    // Reset mid-scan at A=4 with start held high throughout.
    mask  = 8'hFF;
    dwell = 4'd1;
    start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      check_obs("rst_pre", sample(), mk(3'(i / 2), 1'b1, 1'b1, 1'b0));
    end
    rst = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    check_obs("rst_mid", sample(), mk(3'd0, 1'b0, 1'b0, 1'b0));
    step();
    check_obs("rst_no_done", sample(), mk(3'd0, 1'b0, 1'b0, 1'b0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addr_scan_ctrl.md
ADDR_SCAN_CTRL -- requirements
Module: addr_scan_ctrl

Interface
REQ-001 The block SHALL take parameter DWELL_W, default 4, as the width of the per-slot dwell count.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk SHALL be an input of width 1: the single clock, rising edge.
REQ-004 Port rst SHALL be an input of width 1: synchronous, active-high reset.
REQ-005 Port start SHALL be an input of width 1: request a scan, sampled only in IDLE.
REQ-006 Port abort SHALL be an input of width 1: terminate the scan, with priority over all else except rst.
REQ-007 Port mask SHALL be an input of width 8: slot enables, bit n enables address n.
REQ-008 Port dwell SHALL be an input of width DWELL_W: each slot is held for dwell+1 cycles.
REQ-009 Port A SHALL be an output of width 3: address to the downstream 3-to-8 decoder.
REQ-010 Port E SHALL be an output of width 1: decoder enable.
REQ-011 Port busy SHALL be an output of width 1: high in SCAN and DONE.
REQ-012 Port done SHALL be an output of width 1: one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have states IDLE, SCAN and DONE, with all outputs registered.
REQ-014 When start=1 in IDLE, the block SHALL latch mask and dwell. If the latched mask is non-zero, the next state SHALL be SCAN with A equal to the lowest set bit index. If the latched mask is zero, the next state SHALL be DONE.
REQ-015 In SCAN, E SHALL be 1 and A SHALL hold for exactly dwell+1 cycles, counted by a DWELL_W-bit down-counter.
REQ-016 When the counter expires, A SHALL advance to the next higher set bit of the latched mask, with no E gap between slots.
REQ-017 After the highest set slot expires, the block SHALL enter DONE, with E=0 in that cycle.
REQ-018 DONE SHALL last one cycle with done=1 and busy=1; the block SHALL then return to IDLE.
REQ-019 start SHALL be ignored outside IDLE. Changes to mask and dwell during a scan SHALL have no effect until the next start.
REQ-020 When abort=1 in SCAN or DONE, the next cycle SHALL be IDLE with E=0, busy=0 and done=0. abort in IDLE SHALL have no effect.
REQ-021 When start and abort are both high in IDLE, abort SHALL win: the block stays in IDLE.
REQ-022 In IDLE, A SHALL hold its last value and E SHALL be 0.
REQ-023 With dwell=0, each enabled slot SHALL be held for exactly 1 cycle.

Reset
REQ-024 On rst=1 at a clock edge, the block SHALL enter IDLE with A=3'b000, E=0, busy=0, done=0, counter=0 and latched mask=0, regardless of state.
REQ-025 Reset mid-scan SHALL drop E in the cycle after the reset edge, and SHALL produce no done pulse.

Configuration
REQ-026 When SCAN_WRAP_EN is defined, after the highest set slot the block SHALL wrap to the lowest set slot instead of entering DONE; the scan ends only on abort or rst, and done SHALL pulse only for the zero-mask case.
REQ-027 When SCAN_WRAP_EN is not defined, the block SHALL follow REQ-017 (single pass).

Structure
REQ-028 Package scan_pkg SHALL hold the state enum (IDLE, SCAN, DONE), NUM_SLOTS=8 and ADDR_W=3.
REQ-029 A combinational sub-module next_slot_find SHALL take mask[7:0] and cur[2:0] and return next[2:0] plus a found flag. The found flag is 1 only if a set bit exists strictly above cur, or with cur forced below 0 for first-slot search.

Verification
REQ-030 Test: mask=8'hFF, dwell=0, start pulse. Required: A steps 0..7, one cycle each, with E=1 for 8 cycles; then done=1 for 1 cycle; then busy=0.
REQ-031 Test: mask=8'b1010_0100, dwell=2. Required: A=2, 5, 7, each held 3 cycles with E=1 throughout; done one cycle after A=7 ends.
REQ-032 Test: mask=8'h00, start. Required: E stays 0; done=1 exactly one cycle after start; busy=1 for that cycle only.
REQ-033 Test: mask=8'hFF, dwell=3; abort asserted on the 6th SCAN cycle. Required: next cycle IDLE with E=0 and done never asserted. A second start is accepted thereafter.
REQ-034 Test: rst asserted mid-scan at A=4. Required: A=0, E=0, busy=0 on the next cycle; start held high during the scan is ignored.
REQ-035 Test (SCAN_WRAP_EN defined): mask=8'b1000_0001, dwell=0. Required: A alternates 0, 7, 0, 7 with E=1 continuously and no done; abort stops the scan.
